// File: rtl/barrel_rotator_pkg.sv
// Shared constants and types for the barrel rotator arbiter.
// The optional statistics port set is enabled by BARREL_ROTATOR_ARB_STATS_EN.
package barrel_rotator_pkg;

  localparam logic ROT_RIGHT = 1'b0;
  localparam logic ROT_LEFT  = 1'b1;

  localparam int unsigned STATS_WIDTH = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/parameterized_barrel_rotator.sv
// Combinational log-depth barrel rotator; dir 0 rotates right, 1 rotates left.
module parameterized_barrel_rotator
  import barrel_rotator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [SHIFT_WIDTH-1:0] amount_i,
  input  logic                   dir_i,
  output logic [DATA_WIDTH-1:0]  data_o
);

  function automatic logic [DATA_WIDTH-1:0] rotate_by(input logic [DATA_WIDTH-1:0] x,
                                                      input int unsigned           r,
                                                      input logic                  dir);
    logic [2*DATA_WIDTH-1:0] dbl;
    dbl = {x, x};
    if (dir == ROT_LEFT) begin
      dbl       = dbl << r;
      rotate_by = dbl[2*DATA_WIDTH-1:DATA_WIDTH];
    end else begin
      dbl       = dbl >> r;
      rotate_by = dbl[DATA_WIDTH-1:0];
    end
  endfunction

  logic [DATA_WIDTH-1:0] stage [SHIFT_WIDTH+1];

  assign stage[0] = data_i;

  // Each stage rotates by 2^s reduced mod width, so non-power-of-2 widths compose correctly.
  for (genvar s = 0; s < int'(SHIFT_WIDTH); s++) begin : g_stage
    localparam int unsigned STEP = (32'(1) << s) % DATA_WIDTH;
    assign stage[s+1] = amount_i[s] ? rotate_by(stage[s], STEP, dir_i) : stage[s];
  end

  assign data_o = stage[SHIFT_WIDTH];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  output logic [NUM_REQ-1:0]  grant_c_o,
  output logic [ID_WIDTH-1:0] grant_idx_c_o,
  output logic                any_valid_c_o
);

  logic [ID_WIDTH-1:0] cand;
  logic                found;

  always_comb begin
    grant_c_o     = '0;
    grant_idx_c_o = '0;
    cand          = '0;
    found         = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_WIDTH'((32'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_idx_c_o = cand;
      end
    end
    if (found) grant_c_o[grant_idx_c_o] = 1'b1;
    any_valid_c_o = found;
  end

endmodule

// File: rtl/barrel_rotator_arbiter.sv
// Round-robin sharing of one barrel rotator across NUM_REQ requesters, one output register.
// Define BARREL_ROTATOR_ARB_STATS_EN to add stall_count / grant_total counters.
module barrel_rotator_arbiter
  import barrel_rotator_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHIFT_WIDTH = $clog2(DATA_WIDTH),
  parameter int unsigned ID_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ*SHIFT_WIDTH-1:0] req_amount,
  input  logic [NUM_REQ-1:0]             req_dir,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [ID_WIDTH-1:0]            out_id
`ifdef BARREL_ROTATOR_ARB_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0]         stall_count,
  output logic [STATS_WIDTH-1:0]         grant_total
`endif
);

  out_state_e            state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;

  logic [NUM_REQ-1:0]     grant;
  logic [ID_WIDTH-1:0]    grant_idx;
  logic                   any_valid;
  logic                   can_accept;
  logic                   accept;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [SHIFT_WIDTH-1:0] sel_amount;
  logic                   sel_dir;
  logic [SHIFT_WIDTH-1:0] eff_amount;
  logic [DATA_WIDTH-1:0]  rot_data;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req_i         (req_valid),
    .ptr_i         (rr_ptr_q),
    .grant_c_o     (grant),
    .grant_idx_c_o (grant_idx),
    .any_valid_c_o (any_valid)
  );

  assign can_accept = (state_q == EMPTY) | out_ready;
  assign accept     = any_valid & can_accept;
  assign req_ready  = grant & {NUM_REQ{can_accept}};

  // One-hot operand mux in front of the shared rotator.
  always_comb begin
    sel_data   = '0;
    sel_amount = '0;
    sel_dir    = ROT_RIGHT;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data   = sel_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_amount = sel_amount | req_amount[i*SHIFT_WIDTH +: SHIFT_WIDTH];
        sel_dir    = sel_dir | req_dir[i];
      end
    end
  end

  // Collapses to a wire when DATA_WIDTH is a power of two.
  assign eff_amount = SHIFT_WIDTH'(32'(sel_amount) % DATA_WIDTH);

  parameterized_barrel_rotator #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_rot (
    .data_i   (sel_data),
    .amount_i (eff_amount),
    .dir_i    (sel_dir),
    .data_o   (rot_data)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    id_d     = id_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
      data_d   = rot_data;
      id_d     = grant_idx;
    end
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (out_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      rr_ptr_q <= '0;
      data_q   <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      id_q     <= id_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;

`ifdef BARREL_ROTATOR_ARB_STATS_EN
  logic [STATS_WIDTH-1:0] stall_q, stall_d;
  logic [STATS_WIDTH-1:0] gtot_q, gtot_d;

  // Stall count saturates; grant total wraps.
  always_comb begin
    stall_d = stall_q;
    gtot_d  = gtot_q;
    if ((state_q == FULL) && !out_ready && (stall_q != '1)) stall_d = stall_q + STATS_WIDTH'(1);
    if (accept) gtot_d = gtot_q + STATS_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      gtot_q  <= '0;
    end else begin
      stall_q <= stall_d;
      gtot_q  <= gtot_d;
    end
  end

  assign stall_count = stall_q;
  assign grant_total = gtot_q;
`endif

endmodule

// File: tb/tb_barrel_rotator_arbiter.sv
// Self-checking bench for barrel_rotator_arbiter (32-bit x4 and 24-bit x2 instances).
module tb_barrel_rotator_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 5;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0, req_dir = '0;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_data = '0;
  logic [N*SW-1:0] req_amount = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W-1:0]    out_data;
  logic [IW-1:0]   out_id;

  logic [1:0]  r_valid = '0, r_dir = '0;
  logic [1:0]  r_ready;
  logic [47:0] r_data = '0;
  logic [9:0]  r_amount = '0;
  logic        r_ovalid;
  logic        r_oready = 1'b1;
  logic [23:0] r_odata;
  logic [0:0]  r_oid;

`ifdef BARREL_ROTATOR_ARB_STATS_EN
  logic [15:0] stall_count, grant_total, r_stall, r_gtot;
`endif

  barrel_rotator_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_amount(req_amount), .req_dir(req_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
`ifdef BARREL_ROTATOR_ARB_STATS_EN
    , .stall_count(stall_count), .grant_total(grant_total)
`endif
  );

  barrel_rotator_arbiter #(.NUM_REQ(2), .DATA_WIDTH(24)) dut24 (
    .clk(clk), .rst(rst), .req_valid(r_valid), .req_ready(r_ready),
    .req_data(r_data), .req_amount(r_amount), .req_dir(r_dir),
    .out_valid(r_ovalid), .out_ready(r_oready), .out_data(r_odata), .out_id(r_oid)
`ifdef BARREL_ROTATOR_ARB_STATS_EN
    , .stall_count(r_stall), .grant_total(r_gtot)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference rotation from the definition: right moves bit (i+a) to i.
  function automatic logic [31:0] ref_rot(input logic [31:0] x, input int w, input int amt,
                                          input bit left);
    logic [31:0] r;
    int a;
    r = '0;
    a = amt % w;
    for (int i = 0; i < w; i++) begin
      if (left) r[(i + a) % w] = x[i];
      else      r[i] = x[(i + a) % w];
    end
    return r;
  endfunction

  task automatic set_req(input int i, input bit v, input logic [31:0] d, input logic [4:0] a,
                         input bit dir);
    req_valid[i]        = v;
    req_data[i*W +: W]  = d;
    req_amount[i*SW +: SW] = a;
    req_dir[i]          = dir;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    r_valid   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] d;
    logic [4:0]  a;
    bit          left;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [23:0] d;
    logic [4:0]  a;
    bit          left;
    logic [23:0] exp;
  } vec24_t;

  vec_t   tbl[8];
  vec24_t tbl24[4];

  bit          pv[N];
  logic [31:0] pd[N];
  int          pa[N];
  bit          pdir[N];
  int          mptr, g;
  bit          mfull, cacc;
  logic [31:0] mdata;
  int          mid;
  logic [N-1:0] exp_ready;
  logic [31:0] held;

  initial begin
    tbl[0] = '{32'h8000_0001, 5'd1,  1'b1, 32'h0000_0003};
    tbl[1] = '{32'h8000_0001, 5'd1,  1'b0, 32'hC000_0000};
    tbl[2] = '{32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678};
    tbl[3] = '{32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678};
    tbl[4] = '{32'h1234_5678, 5'd4,  1'b1, 32'h2345_6781};
    tbl[5] = '{32'h1234_5678, 5'd8,  1'b0, 32'h7812_3456};
    tbl[6] = '{32'h0000_0001, 5'd31, 1'b1, 32'h8000_0000};
    tbl[7] = '{32'hF000_0000, 5'd16, 1'b0, 32'h0000_F000};
    tbl24[0] = '{24'h000001, 5'd25, 1'b0, 24'h800000};
    tbl24[1] = '{24'hABCDEF, 5'd0,  1'b1, 24'hABCDEF};
    tbl24[2] = '{24'hABCDEF, 5'd0,  1'b0, 24'hABCDEF};
    tbl24[3] = '{24'h000001, 5'd30, 1'b1, 24'h000040};

    do_reset();
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_out_data", 64'(out_data), 64'(0));
    chk("reset_out_id", 64'(out_id), 64'(0));
    chk("reset_req_ready", 64'(req_ready), 64'(0));

    // Single request on requester 2.
    out_ready = 1'b1;
    set_req(2, 1'b1, 32'h8000_0001, 5'd1, 1'b1);
    #1 chk("single_ready", 64'(req_ready), 64'(4'b0100));
    @(posedge clk); #1;
    set_req(2, 1'b0, 32'h0, 5'd0, 1'b0);
    chk("single_valid", 64'(out_valid), 64'(1));
    chk("single_data", 64'(out_data), 64'(32'h0000_0003));
    chk("single_id", 64'(out_id), 64'(2));
    #1 chk("single_ready_once", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    chk("single_drained", 64'(out_valid), 64'(0));

    // Table vectors, one requester at a time.
    for (int i = 0; i < 8; i++) begin
      set_req(i % N, 1'b1, tbl[i].d, tbl[i].a, tbl[i].left);
      #1 chk($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(1 << (i % N)));
      @(posedge clk); #1;
      set_req(i % N, 1'b0, 32'h0, 5'd0, 1'b0);
      chk($sformatf("tbl%0d_data", i), 64'(out_data), 64'(tbl[i].exp));
      chk($sformatf("tbl%0d_id", i), 64'(out_id), 64'(i % N));
    end

    // Fairness with all requesters valid.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'hA500_0000 | 32'(i), 5'(i + 3), 1'b1);
    for (int c = 0; c < 8; c++) begin
      #1 chk($sformatf("rr%0d_ready", c), 64'(req_ready), 64'(1 << (c % N)));
      @(posedge clk); #1;
      chk($sformatf("rr%0d_id", c), 64'(out_id), 64'(c % N));
      chk($sformatf("rr%0d_data", c), 64'(out_data),
          64'(ref_rot(32'hA500_0000 | 32'(c % N), 32, (c % N) + 3, 1'b1)));
    end

    // Backpressure while FULL holding id 3; next grant must still be 0.
    out_ready = 1'b0;
    held = ref_rot(32'hA500_0003, 32, 6, 1'b1);
    for (int c = 0; c < 5; c++) begin
      #1 chk($sformatf("bp%0d_ready", c), 64'(req_ready), 64'(0));
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", c), 64'(out_valid), 64'(1));
      chk($sformatf("bp%0d_id", c), 64'(out_id), 64'(3));
      chk($sformatf("bp%0d_data", c), 64'(out_data), 64'(held));
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(out_valid), 64'(1));
    chk("bp_release_id", 64'(out_id), 64'(0));
    req_valid = '0;

    // Non-power-of-2 width instance.
    for (int i = 0; i < 4; i++) begin
      r_valid[i % 2] = 1'b1;
      r_data[(i % 2)*24 +: 24] = tbl24[i].d;
      r_amount[(i % 2)*5 +: 5] = tbl24[i].a;
      r_dir[i % 2] = tbl24[i].left;
      @(posedge clk); #1;
      r_valid = '0;
      chk($sformatf("w24_%0d_data", i), 64'(r_odata), 64'(tbl24[i].exp));
      chk($sformatf("w24_%0d_id", i), 64'(r_oid), 64'(i % 2));
    end

    // Async reset while FULL with rr_ptr at 2.
    do_reset();
    set_req(1, 1'b1, 32'h0000_00FF, 5'd0, 1'b0);
    @(posedge clk); #1;
    set_req(1, 1'b0, 32'h0, 5'd0, 1'b0);
    chk("ar_full", 64'(out_valid), 64'(1));
    #2 rst = 1'b1;
    #1 chk("ar_valid_drop", 64'(out_valid), 64'(0));
    chk("ar_data_clear", 64'(out_data), 64'(0));
    set_req(1, 1'b1, 32'h11, 5'd0, 1'b0);
    set_req(3, 1'b1, 32'h33, 5'd0, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("ar_first_grant", 64'(req_ready), 64'(4'b0010));
    @(posedge clk); #1;
    chk("ar_first_id", 64'(out_id), 64'(1));
    req_valid = '0;

`ifdef BARREL_ROTATOR_ARB_STATS_EN
    do_reset();
    out_ready = 1'b1;
    set_req(0, 1'b1, 32'h5, 5'd1, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    req_valid = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stats_stall", 64'(stall_count), 64'(3));
    chk("stats_grant", 64'(grant_total), 64'(7));
`endif

    // Randomised traffic against the reference model.
    do_reset();
    mptr = 0; mfull = 1'b0; mdata = '0; mid = 0;
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && ($urandom_range(1, 0) == 1)) begin
          pv[i]   = 1'b1;
          pd[i]   = $urandom;
          pa[i]   = $urandom_range(31, 0);
          pdir[i] = 1'($urandom_range(1, 0));
        end
        set_req(i, pv[i], pd[i], 5'(pa[i]), pdir[i]);
      end
      out_ready = ($urandom_range(3, 0) != 0);
      #1;
      cacc = !mfull || out_ready;
      g = -1;
      for (int k = 0; k < N; k++) if (g < 0 && pv[(mptr + k) % N]) g = (mptr + k) % N;
      exp_ready = (g >= 0 && cacc) ? N'(1 << g) : '0;
      chk("rnd_ready", 64'(req_ready), 64'(exp_ready));
      @(posedge clk); #1;
      if (exp_ready != '0) begin
        mfull = 1'b1;
        mdata = ref_rot(pd[g], 32, pa[g], pdir[g]);
        mid   = g;
        mptr  = (g + 1) % N;
        pv[g] = 1'b0;
      end else if (mfull && out_ready) begin
        mfull = 1'b0;
      end
      chk("rnd_valid", 64'(out_valid), 64'(mfull));
      if (mfull) begin
        chk("rnd_data", 64'(out_data), 64'(mdata));
        chk("rnd_id", 64'(out_id), 64'(mid));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/barrel_rotator_arbiter.md
# barrel_rotator_arbiter

Shares one combinational barrel rotator between `NUM_REQ` independent requesters. Each requester presents data, rotate amount and direction under a valid/ready handshake. A round-robin arbiter grants at most one request per cycle and drives the shared rotator. The result is captured in a single registered output stage tagged with the requester ID. The block sits between rotate-issuing clients (crypto/hash round logic, bit-field extractors) and the shared `parameterized_barrel_rotator` datapath.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 32: rotator data width, ≥2.
- `SHIFT_WIDTH`, $clog2(DATA_WIDTH): rotate-amount width.
- `ID_WIDTH`, $clog2(NUM_REQ): requester-ID width.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester request valid.
- `req_ready` out NUM_REQ: per-requester accept; at most one bit high per cycle.
- `req_data` in NUM_REQ*DATA_WIDTH: flat bus; requester i at slice [i*DATA_WIDTH +: DATA_WIDTH].
- `req_amount` in NUM_REQ*SHIFT_WIDTH: flat rotate amounts, same slicing.
- `req_dir` in NUM_REQ: 0 = right, 1 = left.
- `out_valid` out 1: result register holds a result.
- `out_ready` in 1: downstream accept.
- `out_data` out DATA_WIDTH: rotated result.
- `out_id` out ID_WIDTH: index of the requester that produced `out_data`.

## Operation
- Output stage FSM has two states:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on `out_ready` with no accept.
  - FULL → FULL on `out_ready` with accept (back-to-back).
  - FULL holds while `out_ready` = 0.
- Accept is allowed when `can_accept = (state==EMPTY) | out_ready`.
- Round-robin arbitration:
  - Register `rr_ptr` (ID_WIDTH) marks the highest-priority index.
  - The grant is the first `req_valid` bit at or above `rr_ptr`, wrapping modulo NUM_REQ.
  - `req_ready[i] = grant[i] & can_accept`.
  - Combinational dependence of `req_ready` on `req_valid` is permitted; requesters must not gate `req_valid` on `req_ready`.
- On accept of index g:
  - `rr_ptr` ← (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
  - The output register captures the rotated data, and `out_id` ← g.
- `rr_ptr` holds when there is no accept, including when requests are blocked by backpressure.
- Amount arithmetic: the effective amount is `req_amount mod DATA_WIDTH`.
  - For power-of-2 DATA_WIDTH this is the raw value.
  - Otherwise, amounts ≥ DATA_WIDTH are reduced before reaching the rotator.
  - Amount 0 passes data unchanged in either direction.
- A request with `req_valid` high must hold data, amount and dir stable until accepted.
- While `out_valid` & !`out_ready`, `out_data`/`out_id` hold stable.
- No valid requests in a cycle: no grant, and all `req_ready` = 0.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `out_id` = 0, `rr_ptr` = 0, state = EMPTY. `req_ready` evaluates to 0 because no grant is possible while all `req_valid` are low.
- Latency: accept at edge N gives `out_valid` = 1 with the result after edge N.
- Throughput: one result per cycle while `out_ready` = 1.
- Simultaneous output drain and new accept in one cycle: the new result replaces the old one with no bubble.
- Reset asserted mid-operation:
  - The in-flight result is dropped, and `out_valid` falls immediately (asynchronously).
  - Arbitration restarts at index 0 after reset deasserts.
- Fairness: with all requesters continuously valid and `out_ready` = 1, grants cycle 0,1,…,NUM_REQ-1. Each requester waits at most NUM_REQ-1 accept cycles.

## Configuration
- Macro `BARREL_ROTATOR_ARB_STATS_EN`, when defined, adds:
  - Output port `stall_count` (16 bits, saturating): increments each cycle with `out_valid` & !`out_ready`.
  - Output port `grant_total` (16 bits, wrapping): increments on each accept.
  - Both counters reset to 0.
- When the macro is undefined, neither port nor its counter exists, and behaviour is otherwise identical.

## Structure
- The shared package `barrel_rotator_pkg` holds:
  - the direction constants `ROT_RIGHT` = 1'b0 and `ROT_LEFT` = 1'b1;
  - the output-state enum (EMPTY, FULL);
  - the stats counter width constant (16).
- Sub-modules:
  - One `rr_arbiter` sub-module (inputs: req vector and ptr; output: one-hot grant, grant index, any-valid).
  - The existing `parameterized_barrel_rotator` is instanced as the datapath.

## Test plan
- Reset then single request: req 2 valid, data 0x80000001, amount 1, left → `out_data` = 0x00000003, `out_id` = 2 one cycle after accept; `req_ready[2]` high for exactly 1 cycle.
- All 4 requesters valid continuously, `out_ready` = 1 → grant order 0,1,2,3,0,…, one result per cycle.
- Backpressure: `out_ready` = 0 for 5 cycles while FULL → `out_data` and `out_id` stable, all `req_ready` = 0, `rr_ptr` unchanged. Release → drain and accept in the same cycle.
- Non-power-of-2: DATA_WIDTH = 24, amount 25, right, data 0x000001 → `out_data` = 0x800000 (effective amount 1). Amount 0 → data unchanged.
- Async reset asserted while FULL → `out_valid` drops immediately; the first grant after reset goes to the lowest valid index.
- With `BARREL_ROTATOR_ARB_STATS_EN`: 3 stall cycles and 7 accepts → `stall_count` = 3, `grant_total` = 7.
